pre_i_grad_gen: RTL and testbench
=================================

Name: pre_i_grad_gen

Overview:
- Pre-intra gradient source for one 64x64 LCU.
- Reads 8x8 luma blocks from the pre-intra pixel buffer in z-order and computes a 3x3 Sobel gradient (gx, gy) at six interior sample points per block.
- Generates the cnt / blockcnt / counterrun1 / counterrun2 timing consumed by the DC/planar mode-decision stage.
- It is the producing end of that gradient/timing interface.

Parameters:
- CNT_MAX, 39, last cnt value in a block slot; slot length is CNT_MAX+1 cycles; legal range 17..63.
- BLK_NUM, 64, number of 8x8 blocks per LCU; blockcnt runs 0..BLK_NUM.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle LCU start pulse; honoured in IDLE only
- done  out  1  one-cycle pulse at the end of the last slot
- busy  out  1  high while in RUN
- pix_rd_en  out  1  block-row read strobe
- pix_rd_blk  out  6  z-order block index
- pix_rd_row  out  3  row within block
- pix_rd_data  in  64  row of 8 pixels, column k at bits [8k+7:8k]; valid 1 cycle after pix_rd_en
- gx  out  11  signed Sobel-x
- gy  out  11  signed Sobel-y
- cnt  out  6  cycle index in slot
- blockcnt  out  7  slot index; 0 = prefetch slot
- counterrun1  out  1  gradient-valid / accumulator-clear window
- counterrun2  out  1  accumulate window

Behaviour:
- Single clock clk. Reset rstn is asynchronous, active-low.
- Reset: all outputs 0, FSM = IDLE, row buffer cleared.
- FSM states:
  - IDLE: on start, go to RUN with cnt=0 and blockcnt=0.
  - RUN: cnt increments 0..CNT_MAX and wraps to 0; blockcnt increments on the wrap. At blockcnt==BLK_NUM and cnt==CNT_MAX, assert done for 1 cycle, return to IDLE, and set cnt=0, blockcnt=0.
  - In IDLE, cnt = blockcnt = 0, busy = 0.
  - start while in RUN is ignored.
- Fetch:
  - In slot b (0..BLK_NUM-1), at cnt 8..15: pix_rd_en=1, pix_rd_blk=b[5:0], pix_rd_row=cnt-8.
  - Data returned at cnt 9..16 is written to row buffer entry 0..7.
  - Slot BLK_NUM performs no read.
  - A single 8x64-bit buffer suffices because gradients use it only from cnt CNT_MAX of slot b through cnt 5 of slot b+1.
- Gradient emission:
  - In slot b+1 (blockcnt 1..BLK_NUM), during the cycle with cnt=c for c in 0..5, gx/gy present the gradient of block b at row r=c+1, column 4.
  - gx/gy are registered, so the value for c is computed on the preceding cycle; cnt==CNT_MAX of the previous slot precomputes c=0.
  - gx = (p[r-1][5]+2p[r][5]+p[r+1][5]) - (p[r-1][3]+2p[r][3]+p[r+1][3])
  - gy = (p[r+1][3]+2p[r+1][4]+p[r+1][5]) - (p[r-1][3]+2p[r-1][4]+p[r-1][5])
  - Compute at 12 bits; the result range is ±1020, so it fits 11-bit signed with no saturation.
  - gx = gy = 0 outside cnt 0..5 and throughout slot 0.
- Windows (blockcnt != 0 only):
  - counterrun1 = 1 at cnt 0..5.
  - counterrun2 = 1 at cnt 1..6.
  - Consequence: a downstream accumulator that clears on counterrun1 & !counterrun2 and adds a latched |gx|+|gy| holds the sum of six samples at cnt 7.
- Total run length: (BLK_NUM+1)*(CNT_MAX+1) cycles from start to done, inclusive. With defaults this is 2600 cycles.
- Reset asserted mid-run aborts immediately: no done pulse, outputs 0. A new start restarts at blockcnt 0.
- start coincident with the done cycle is ignored.

Optional Feature:
- Macro: PRE_I_RD_LAT2_EN.
- Defined: pix_rd_data is valid 2 cycles after pix_rd_en, and capture moves to cnt 10..17. Read issue timing is unchanged. CNT_MAX must be ≥18 (elaboration $error otherwise).
- Undefined: 1-cycle read latency, capture at cnt 9..16.

Decomposition:
- Shared package pre_i_pkg holds:
  - PIX_W=8, GRAD_W=11, CNT_W=6, BLKCNT_W=7.
  - Window constants CR1_FIRST=0, CR1_LAST=5, CR2_FIRST=1, CR2_LAST=6, RD_FIRST=8.
  - FSM state enum {IDLE, RUN}.
- One natural sub-module, pre_i_sobel3x3: combinational, takes a 3x3 pixel window and returns signed gx/gy. The top module owns the counters, fetch, row buffer and output registers.

Test Plan:
- Flat block, all pixels 128: in slot 1, gx=gy=0 at cnt 0..5; counterrun1 high at cnt 0..5; counterrun2 high at cnt 1..6.
- Horizontal ramp p=10*col: gx=80, gy=0 for all six samples. Vertical ramp p=10*row: gx=0, gy=80.
- Step edge, cols ≥4 = 255, others 0: gx=+1020. Inverted edge: gx=-1020. No wrap on the 11-bit output.
- Timing from start:
  - First pix_rd_en at blockcnt=0, cnt=8.
  - pix_rd_blk equals the slot number for slots 0..63; no read in slot 64.
  - done pulses exactly 2600 cycles after start, then busy=0.
- Distinct per-block patterns (block b filled with p=b*col%256, clipped): slot b+1 emits block b's gradients, checked against a scoreboard model for all 64 blocks.
- rstn low in slot 10 at cnt 20: all outputs 0 asynchronously. start pulsed during RUN is ignored. A new start after reset begins again at blockcnt 0.

Source files
------------

// File: rtl/pre_i_pkg.sv
// rtl/pre_i_pkg.sv - shared widths, window constants and FSM state for pre_i_grad_gen
//
// Purpose: common definitions imported by pre_i_sobel3x3 and pre_i_grad_gen.
// Ports: none (package).

package pre_i_pkg;

  // Datapath widths
  localparam int PIX_W    = 8;
  localparam int GRAD_W   = 11;
  localparam int CNT_W    = 6;
  localparam int BLKCNT_W = 7;

  // Internal Sobel arithmetic width (|result| <= 1020 plus sign headroom)
  localparam int SOBEL_W  = 12;

  // Block geometry
  localparam int BLK_ROWS   = 8;
  localparam int SOBEL_COL0 = 3;  // leftmost column of the 3x3 window (centre column 4)

  // cnt windows inside a slot
  localparam int CR1_FIRST = 0;
  localparam int CR1_LAST  = 5;
  localparam int CR2_FIRST = 1;
  localparam int CR2_LAST  = 6;
  localparam int RD_FIRST  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pre_i_sobel3x3.sv
// rtl/pre_i_sobel3x3.sv - combinational 3x3 Sobel gradient
//
// Purpose: computes signed Sobel-x / Sobel-y of a 3x3 window of unsigned pixels.
// Ports:
//   win [0:2][0:2]  in   pixel window, win[row][col]; row 0 is the upper row,
//                        col 0 the left column
//   gx              out  signed horizontal gradient (right minus left)
//   gy              out  signed vertical gradient (lower minus upper)

module pre_i_sobel3x3
  import pre_i_pkg::*;
(
  input  logic        [PIX_W-1:0]  win [0:2][0:2],
  output logic signed [GRAD_W-1:0] gx,
  output logic signed [GRAD_W-1:0] gy
);

  logic signed [SOBEL_W-1:0] e [0:2][0:2];
  logic signed [SOBEL_W-1:0] gx_w;
  logic signed [SOBEL_W-1:0] gy_w;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        e[i][j] = $signed({{(SOBEL_W-PIX_W){1'b0}}, win[i][j]});
      end
    end

    gx_w = (e[0][2] + (e[1][2] <<< 1) + e[2][2])
         - (e[0][0] + (e[1][0] <<< 1) + e[2][0]);
    gy_w = (e[2][0] + (e[2][1] <<< 1) + e[2][2])
         - (e[0][0] + (e[0][1] <<< 1) + e[0][2]);

    // Magnitude never exceeds 4*255, so dropping the top bit loses nothing.
    gx = gx_w[GRAD_W-1:0];
    gy = gy_w[GRAD_W-1:0];
  end

endmodule

// File: rtl/pre_i_grad_gen.sv
// rtl/pre_i_grad_gen.sv - pre-intra Sobel gradient source and slot timing for one 64x64 LCU
//
// Purpose: walks BLK_NUM+1 slots of CNT_MAX+1 cycles. In slot b (b < BLK_NUM) it
// reads the eight rows of 8x8 block b into a row buffer; in slot b+1 it emits
// six registered Sobel samples (rows 1..6, column 4) of block b at cnt 0..5,
// together with the counterrun1/counterrun2 windows used downstream.
// Configuration macro: PRE_I_RD_LAT2_EN -- when defined, pix_rd_data arrives two
// cycles after pix_rd_en (capture at cnt 10..17, CNT_MAX >= 18); otherwise one cycle.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              LCU start pulse, honoured in IDLE only
//   done               one-cycle pulse on the last cycle of the last slot
//   busy               high while running
//   pix_rd_en/blk/row  block-row read request to the pixel buffer
//   pix_rd_data        returned row, pixel k at bits [8k+7:8k]
//   gx, gy             signed gradient samples
//   cnt, blockcnt      cycle-in-slot and slot index
//   counterrun1/2      gradient-valid and accumulate windows

module pre_i_grad_gen
  import pre_i_pkg::*;
#(
  parameter int CNT_MAX = 39,
  parameter int BLK_NUM = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  output logic                       done,
  output logic                       busy,
  output logic                       pix_rd_en,
  output logic        [5:0]          pix_rd_blk,
  output logic        [2:0]          pix_rd_row,
  input  logic        [63:0]         pix_rd_data,
  output logic signed [GRAD_W-1:0]   gx,
  output logic signed [GRAD_W-1:0]   gy,
  output logic        [CNT_W-1:0]    cnt,
  output logic        [BLKCNT_W-1:0] blockcnt,
  output logic                       counterrun1,
  output logic                       counterrun2
);

`ifdef PRE_I_RD_LAT2_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam int RD_LAST   = RD_FIRST + BLK_ROWS - 1;
  localparam int CAP_FIRST = RD_FIRST + RD_LAT;
  localparam int CAP_LAST  = CAP_FIRST + BLK_ROWS - 1;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [BLKCNT_W-1:0] BLK_LAST = BLKCNT_W'(BLK_NUM);

  // The row buffer must be complete before the c=0 precompute at cnt CNT_MAX.
  generate
    if (CNT_MAX < CAP_LAST + 1 || CNT_MAX > 63) begin : g_bad_cnt_max
      $error("pre_i_grad_gen: CNT_MAX out of range for the configured read latency");
    end
    if (BLK_NUM < 1 || BLK_NUM > 64) begin : g_bad_blk_num
      $error("pre_i_grad_gen: BLK_NUM must be 1..64");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BLKCNT_W-1:0]        blk_q, blk_d;
  logic [63:0]                rowbuf_q [0:BLK_ROWS-1];
  logic [63:0]                rowbuf_d [0:BLK_ROWS-1];
  logic signed [GRAD_W-1:0]   gx_q, gx_d;
  logic signed [GRAD_W-1:0]   gy_q, gy_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      for (int i = 0; i < BLK_ROWS; i++) begin
        rowbuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      for (int i = 0; i < BLK_ROWS; i++) begin
        rowbuf_q[i] <= rowbuf_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state: slot counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        blk_d = '0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here, including on the done cycle.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (blk_q == BLK_LAST) begin
            state_d = IDLE;
            blk_d   = '0;
          end else begin
            blk_d = blk_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        blk_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the counters
  // ---------------------------------------------------------------------------
  logic             run_st;
  logic             fetch_slot;
  logic [CNT_W-1:0] rd_off;

  always_comb begin
    run_st     = (state_q == RUN);
    fetch_slot = run_st && (blk_q != BLK_LAST);
    rd_off     = cnt_q - CNT_W'(RD_FIRST);

    busy = run_st;
    done = run_st && (cnt_q == CNT_LAST) && (blk_q == BLK_LAST);

    pix_rd_en  = fetch_slot && (cnt_q >= CNT_W'(RD_FIRST)) && (cnt_q <= CNT_W'(RD_LAST));
    pix_rd_blk = pix_rd_en ? blk_q[5:0] : 6'd0;
    pix_rd_row = pix_rd_en ? rd_off[2:0] : 3'd0;

    counterrun1 = run_st && (blk_q != '0)
               && (cnt_q >= CNT_W'(CR1_FIRST)) && (cnt_q <= CNT_W'(CR1_LAST));
    counterrun2 = run_st && (blk_q != '0)
               && (cnt_q >= CNT_W'(CR2_FIRST)) && (cnt_q <= CNT_W'(CR2_LAST));

    cnt      = cnt_q;
    blockcnt = blk_q;
    gx       = gx_q;
    gy       = gy_q;
  end

  // ---------------------------------------------------------------------------
  // Row buffer capture
  // ---------------------------------------------------------------------------
  logic             cap_en;
  logic [CNT_W-1:0] cap_off;

  always_comb begin
    cap_off = cnt_q - CNT_W'(CAP_FIRST);
    cap_en  = fetch_slot && (cnt_q >= CNT_W'(CAP_FIRST)) && (cnt_q <= CNT_W'(CAP_LAST));
    for (int i = 0; i < BLK_ROWS; i++) begin
      rowbuf_d[i] = rowbuf_q[i];
    end
    if (cap_en) begin
      rowbuf_d[cap_off[2:0]] = pix_rd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Gradient precompute: the sample shown at cnt c is formed one cycle earlier,
  // so cnt CNT_MAX of slot b prepares c=0 and cnt 0..4 of slot b+1 prepare c+1.
  // Sample c uses buffer rows c, c+1, c+2 (centre row r=c+1).
  // ---------------------------------------------------------------------------
  logic                     grad_en;
  logic [2:0]               grad_c;
  logic [PIX_W-1:0]         win [0:2][0:2];
  logic signed [GRAD_W-1:0] sobel_gx;
  logic signed [GRAD_W-1:0] sobel_gy;

  always_comb begin
    grad_en = 1'b0;
    grad_c  = 3'd0;
    if (run_st && (cnt_q == CNT_LAST) && (blk_q != BLK_LAST)) begin
      grad_en = 1'b1;
    end else if (run_st && (blk_q != '0) && (cnt_q < CNT_W'(CR1_LAST))) begin
      grad_en = 1'b1;
      grad_c  = 3'(cnt_q + 1'b1);
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win[i][j] = rowbuf_q[grad_c + 3'(i)][PIX_W*(SOBEL_COL0+j) +: PIX_W];
      end
    end
  end

  pre_i_sobel3x3 u_sobel (
    .win (win),
    .gx  (sobel_gx),
    .gy  (sobel_gy)
  );

  always_comb begin
    gx_d = grad_en ? sobel_gx : '0;
    gy_d = grad_en ? sobel_gy : '0;
  end

endmodule

// File: tb/tb_pre_i_grad_gen.sv
// tb/tb_pre_i_grad_gen.sv - self-checking bench for pre_i_grad_gen

module tb_pre_i_grad_gen;

  localparam int CNT_MAX = 39;
  localparam int BLK_NUM = 64;
  localparam int SLOT    = CNT_MAX + 1;
  localparam int RUN_LEN = (BLK_NUM + 1) * SLOT;
  localparam logic [63:0] FILL = {8{8'hA5}};

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic               done;
  logic               busy;
  logic               pix_rd_en;
  logic [5:0]         pix_rd_blk;
  logic [2:0]         pix_rd_row;
  logic [63:0]        pix_rd_data;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [5:0]         cnt;
  logic [6:0]         blockcnt;
  logic               counterrun1;
  logic               counterrun2;

  always #5 clk = ~clk;

  pre_i_grad_gen #(
    .CNT_MAX (CNT_MAX),
    .BLK_NUM (BLK_NUM)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .pix_rd_en   (pix_rd_en),
    .pix_rd_blk  (pix_rd_blk),
    .pix_rd_row  (pix_rd_row),
    .pix_rd_data (pix_rd_data),
    .gx          (gx),
    .gy          (gy),
    .cnt         (cnt),
    .blockcnt    (blockcnt),
    .counterrun1 (counterrun1),
    .counterrun2 (counterrun2)
  );

  // Pixel buffer model: garbage when not addressed so a mistimed capture shows up.
  logic [63:0] mem [0:63][0:7];
`ifdef PRE_I_RD_LAT2_EN
  logic [63:0] rd_d1;
  always @(posedge clk) begin
    rd_d1       <= pix_rd_en ? mem[pix_rd_blk][pix_rd_row] : FILL;
    pix_rd_data <= rd_d1;
  end
`else
  always @(posedge clk) begin
    pix_rd_data <= pix_rd_en ? mem[pix_rd_blk][pix_rd_row] : FILL;
  end
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int q_gx[$];
  int q_gy[$];

  int spec_gx [0:4] = '{0, 80, 0, 1020, -1020};
  int spec_gy [0:4] = '{0, 0, 80, 0, 0};

  function automatic int px(int b, int r, int c);
    return int'(mem[b][r][8*c +: 8]);
  endfunction

  function automatic int model_gx(int b, int r);
    return (px(b, r-1, 5) + 2*px(b, r, 5) + px(b, r+1, 5))
         - (px(b, r-1, 3) + 2*px(b, r, 3) + px(b, r+1, 3));
  endfunction

  function automatic int model_gy(int b, int r);
    return (px(b, r+1, 3) + 2*px(b, r+1, 4) + px(b, r+1, 5))
         - (px(b, r-1, 3) + 2*px(b, r-1, 4) + px(b, r-1, 5));
  endfunction

  // special=1: blocks 0..4 are flat / h-ramp / v-ramp / step / inverted step.
  task automatic fill(input bit special);
    for (int b = 0; b < 64; b++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          int v;
          v = (b * c) % 256;
          if (special) begin
            case (b)
              0: v = 128;
              1: v = 10 * c;
              2: v = 10 * r;
              3: v = (c >= 4) ? 255 : 0;
              4: v = (c >= 4) ? 0 : 255;
              default: ;
            endcase
          end
          mem[b][r][8*c +: 8] = 8'(v);
        end
      end
    end
  endtask

  task automatic load_sb(input bit special);
    q_gx.delete();
    q_gy.delete();
    for (int b = 0; b < BLK_NUM; b++) begin
      for (int c = 0; c < 6; c++) begin
        if (special && b < 5) begin
          q_gx.push_back(spec_gx[b]);
          q_gy.push_back(spec_gy[b]);
        end else begin
          q_gx.push_back(model_gx(b, c + 1));
          q_gy.push_back(model_gy(b, c + 1));
        end
      end
    end
  endtask

  function automatic logic [63:0] pack_obs(input bit mask_grad);
    logic [10:0] ogx;
    logic [10:0] ogy;
    ogx = mask_grad ? 11'd0 : gx;
    ogy = mask_grad ? 11'd0 : gy;
    return 64'({ogx, ogy, blockcnt, cnt, pix_rd_en, pix_rd_blk, pix_rd_row,
                counterrun1, counterrun2, busy, done});
  endfunction

  // Cycle k=1 is the first RUN cycle (slot 0, cnt 0); start is high in cycle 0.
  task automatic run_lcu(input int abort_k);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= RUN_LEN + 2; k++) begin
      logic [63:0] exp;
      int          slot;
      int          c;
      bit          e_rd;
      bit          e_cr1;
      bit          e_cr2;
      @(negedge clk);
      exp = '0;
      e_cr1 = 1'b0;
      if (k <= RUN_LEN) begin
        slot  = (k - 1) / SLOT;
        c     = (k - 1) % SLOT;
        e_rd  = (slot < BLK_NUM) && (c >= 8) && (c <= 15);
        e_cr1 = (slot != 0) && (c <= 5);
        e_cr2 = (slot != 0) && (c >= 1) && (c <= 6);
        exp = 64'({11'd0, 11'd0, 7'(slot), 6'(c), e_rd,
                   e_rd ? 6'(slot) : 6'd0, e_rd ? 3'(c - 8) : 3'd0,
                   e_cr1, e_cr2, 1'b1, (k == RUN_LEN)});
      end
      check($sformatf("timing k=%0d", k), pack_obs(e_cr1), exp);
      if (e_cr1) begin
        if (q_gx.size() == 0) begin
          check("sb_underflow", 64'(q_gx.size()), 64'd1);
        end else begin
          int egx;
          int egy;
          egx = q_gx.pop_front();
          egy = q_gy.pop_front();
          check($sformatf("gx k=%0d", k), 64'(int'(gx)), 64'(egx));
          check($sformatf("gy k=%0d", k), 64'(int'(gy)), 64'(egy));
        end
      end
      // start pulses mid-run and on the done cycle must both be ignored.
      start = (k == 500) || (k == RUN_LEN);
      if (k == abort_k) begin
        rstn = 1'b0;
        #1;
        check("async_reset", pack_obs(1'b0), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        start = 1'b0;
        q_gx.delete();
        q_gy.delete();
        return;
      end
    end
    check("sb_drain", 64'(q_gx.size()), 64'd0);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    check("reset", pack_obs(1'b0), 64'd0);
    rstn = 1'b1;

    fill(1'b1);
    load_sb(1'b1);
    run_lcu(0);

    fill(1'b0);
    load_sb(1'b0);
    run_lcu(10 * SLOT + 20 + 1);

    load_sb(1'b0);
    run_lcu(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
